// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - shared memory bus between the arbiter and the memory
interface mem_arbiter_if;
    logic        BusReqOut;
    logic        BusWeOut;
    logic [63:0] BusAddrOut;
    logic [63:0] BusWdataOut;
    logic        BusAckIn;
    logic [63:0] BusRdataIn;

    modport master (
        output BusReqOut,
        output BusWeOut,
        output BusAddrOut,
        output BusWdataOut,
        input  BusAckIn,
        input  BusRdataIn
    );

    modport slave (
        input  BusReqOut,
        input  BusWeOut,
        input  BusAddrOut,
        input  BusWdataOut,
        output BusAckIn,
        output BusRdataIn
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch / load-store) arbiter onto one memory bus
module mem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          IfReqIn,
    input  logic [63:0]   IfAddrIn,
    output logic          IfReadyOut,
    output logic [63:0]   IfDataOut,
    input  logic          MemReqIn,
    input  logic          MemWeIn,
    input  logic [63:0]   MemAddrIn,
    input  logic [63:0]   MemWdataIn,
    output logic          MemReadyOut,
    output logic [63:0]   MemRdataOut,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_MEM, RESP} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        bus_req_q, bus_we_q;
    logic [63:0] bus_addr_q, bus_wdata_q;
    logic        if_ready_q, mem_ready_q;
    logic [63:0] if_data_q, mem_rdata_q;

    // Mem wins contention until If has been passed over MAX_WAIT times in a row
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (IfReqIn && (!MemReqIn || wait_cnt_q == MAX_CNT)) begin
                    state_d    = GRANT_IF;
                    wait_cnt_d = 4'd0;
                end else if (MemReqIn) begin
                    state_d = GRANT_MEM;
                    if (IfReqIn && wait_cnt_q < MAX_CNT)
                        wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            GRANT_IF, GRANT_MEM: begin
                if (bus.BusAckIn)
                    state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 64'd0;
            bus_wdata_q <= 64'd0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_data_q   <= 64'd0;
            mem_rdata_q <= 64'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (state_d == GRANT_IF) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= IfAddrIn;
                        bus_wdata_q <= 64'd0;
                    end else if (state_d == GRANT_MEM) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= MemWeIn;
                        bus_addr_q  <= MemAddrIn;
                        bus_wdata_q <= MemWdataIn;
                    end
                end
                GRANT_IF, GRANT_MEM: begin
                    // The Ready registers double as the record of who owns RESP
                    if (bus.BusAckIn) begin
                        bus_req_q   <= 1'b0;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= 64'd0;
                        bus_wdata_q <= 64'd0;
                        if (state_q == GRANT_IF) begin
                            if_ready_q <= 1'b1;
                            if_data_q  <= bus.BusRdataIn;
                        end else begin
                            mem_ready_q <= 1'b1;
                            if (!bus_we_q)
                                mem_rdata_q <= bus.BusRdataIn;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign IfReadyOut      = if_ready_q;
    assign IfDataOut       = if_data_q;
    assign MemReadyOut     = mem_ready_q;
    assign MemRdataOut     = mem_rdata_q;
    assign bus.BusReqOut   = bus_req_q;
    assign bus.BusWeOut    = bus_we_q;
    assign bus.BusAddrOut  = bus_addr_q;
    assign bus.BusWdataOut = bus_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed-vector bench for mem_arbiter
module tb_mem_arbiter;
    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ready;
    logic [63:0] if_data;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ready;
    logic [63:0] mem_rdata;

    int n_vec;
    int n_err;

    mem_arbiter_if bus_if ();

    mem_arbiter #(.MAX_WAIT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .IfReqIn     (if_req),
        .IfAddrIn    (if_addr),
        .IfReadyOut  (if_ready),
        .IfDataOut   (if_data),
        .MemReqIn    (mem_req),
        .MemWeIn     (mem_we),
        .MemAddrIn   (mem_addr),
        .MemWdataIn  (mem_wdata),
        .MemReadyOut (mem_ready),
        .MemRdataOut (mem_rdata),
        .bus         (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one rising edge and return to the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_bus_idle(input string tag);
        check_vec({tag, ".req"},   64'(bus_if.BusReqOut), 64'd0);
        check_vec({tag, ".we"},    64'(bus_if.BusWeOut),  64'd0);
        check_vec({tag, ".addr"},  bus_if.BusAddrOut,     64'd0);
        check_vec({tag, ".wdata"}, bus_if.BusWdataOut,    64'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 64'd0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 64'd0; mem_wdata = 64'd0;
        bus_if.BusAckIn = 1'b0; bus_if.BusRdataIn = 64'd0;
        step();
        step();
        check_bus_idle("rst");
        check_vec("rst.if_ready",  64'(if_ready),  64'd0);
        check_vec("rst.mem_ready", 64'(mem_ready), 64'd0);
        check_vec("rst.if_data",   if_data,        64'd0);
        check_vec("rst.mem_rdata", mem_rdata,      64'd0);
        rst_n = 1'b1;
        step();

        // fetch with ack three cycles after BusReqOut rises; request dropped during grant
        if_req = 1'b1; if_addr = 64'h8000_0000;
        step();
        if_req = 1'b0;
        check_vec("f1.req",  64'(bus_if.BusReqOut), 64'd1);
        check_vec("f1.addr", bus_if.BusAddrOut,     64'h8000_0000);
        check_vec("f1.we",   64'(bus_if.BusWeOut),  64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_vec("f1.hold_req", 64'(bus_if.BusReqOut), 64'd1);
            check_vec("f1.hold_we",  64'(bus_if.BusWeOut),  64'd0);
            check_vec("f1.no_ready", 64'(if_ready),         64'd0);
        end
        bus_if.BusAckIn = 1'b1; bus_if.BusRdataIn = 64'h13;
        step();
        bus_if.BusAckIn = 1'b0; bus_if.BusRdataIn = 64'd0;
        check_vec("f1.ready",     64'(if_ready),  64'd1);
        check_vec("f1.mem_ready", 64'(mem_ready), 64'd0);
        check_vec("f1.data",      if_data,        64'h13);
        check_bus_idle("f1.resp");
        step();
        check_vec("f1.pulse_end", 64'(if_ready), 64'd0);
        check_vec("f1.data_hold", if_data,       64'h13);

        // store with same-cycle ack: Ready two edges after the sample, read data untouched
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h1000; mem_wdata = 64'hDEAD_BEEF;
        step();
        mem_req = 1'b0; mem_we = 1'b0;
        check_vec("st.req",   64'(bus_if.BusReqOut), 64'd1);
        check_vec("st.we",    64'(bus_if.BusWeOut),  64'd1);
        check_vec("st.addr",  bus_if.BusAddrOut,     64'h1000);
        check_vec("st.wdata", bus_if.BusWdataOut,    64'hDEAD_BEEF);
        bus_if.BusAckIn = 1'b1; bus_if.BusRdataIn = 64'h5555_AAAA;
        step();
        bus_if.BusAckIn = 1'b0;
        check_vec("st.ready",    64'(mem_ready), 64'd1);
        check_vec("st.if_ready", 64'(if_ready),  64'd0);
        check_vec("st.rdata",    mem_rdata,      64'd0);
        check_vec("st.if_data",  if_data,        64'h13);
        step();
        check_vec("st.pulse_end", 64'(mem_ready), 64'd0);

        // load with same-cycle ack
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h2000;
        step();
        mem_req = 1'b0;
        check_vec("ld.we",   64'(bus_if.BusWeOut), 64'd0);
        check_vec("ld.addr", bus_if.BusAddrOut,    64'h2000);
        bus_if.BusAckIn = 1'b1; bus_if.BusRdataIn = 64'hCAFE;
        step();
        bus_if.BusAckIn = 1'b0;
        check_vec("ld.ready", 64'(mem_ready), 64'd1);
        check_vec("ld.rdata", mem_rdata,      64'hCAFE);
        check_vec("ld.if_data", if_data,      64'h13);
        step();

        // both held high: Mem x4 then If, twice; bus idle for RESP and IDLE between grants
        if_req = 1'b1; if_addr = 64'hA0;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'hB0;
        for (int g = 0; g < 10; g++) begin
            step();
            check_vec($sformatf("arb%0d.req", g),  64'(bus_if.BusReqOut), 64'd1);
            check_vec($sformatf("arb%0d.addr", g), bus_if.BusAddrOut,
                      (g % 5 == 4) ? 64'hA0 : 64'hB0);
            if (g % 5 == 4)
                check_vec($sformatf("arb%0d.wait_cnt", g), 64'(dut.wait_cnt_q), 64'd0);
            bus_if.BusAckIn = 1'b1; bus_if.BusRdataIn = 64'(g + 100);
            step();
            bus_if.BusAckIn = 1'b0;
            check_vec($sformatf("arb%0d.if_ready", g),  64'(if_ready),  (g % 5 == 4) ? 64'd1 : 64'd0);
            check_vec($sformatf("arb%0d.mem_ready", g), 64'(mem_ready), (g % 5 == 4) ? 64'd0 : 64'd1);
            check_vec($sformatf("arb%0d.gap1", g), 64'(bus_if.BusReqOut), 64'd0);
            step();
            check_vec($sformatf("arb%0d.gap2", g), 64'(bus_if.BusReqOut), 64'd0);
        end
        check_vec("arb.if_data",   if_data,   64'd109);
        check_vec("arb.mem_rdata", mem_rdata, 64'd108);
        if_req = 1'b0; mem_req = 1'b0;
        step();

        // reset during GRANT_MEM with the ack withheld
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h3000; mem_wdata = 64'h77;
        step();
        mem_req = 1'b0; mem_we = 1'b0;
        check_vec("rs.req_before", 64'(bus_if.BusReqOut), 64'd1);
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check_bus_idle("rs.async");
        check_vec("rs.if_data",   if_data,        64'd0);
        check_vec("rs.mem_rdata", mem_rdata,      64'd0);
        check_vec("rs.if_ready",  64'(if_ready),  64'd0);
        check_vec("rs.mem_ready", 64'(mem_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        if_req = 1'b1; if_addr = 64'hC0;
        step();
        if_req = 1'b0;
        check_vec("rs.if_grant", bus_if.BusAddrOut,    64'hC0);
        check_vec("rs.if_we",    64'(bus_if.BusWeOut), 64'd0);
        check_vec("rs.no_mem",   64'(mem_ready),       64'd0);
        bus_if.BusAckIn = 1'b1; bus_if.BusRdataIn = 64'h4242;
        step();
        bus_if.BusAckIn = 1'b0;
        check_vec("rs.if_ready",  64'(if_ready),  64'd1);
        check_vec("rs.mem_ready2", 64'(mem_ready), 64'd0);
        check_vec("rs.if_data2",  if_data,        64'h4242);
        step();

        // stray ack in IDLE
        bus_if.BusAckIn = 1'b1; bus_if.BusRdataIn = 64'hFFFF_FFFF;
        step();
        bus_if.BusAckIn = 1'b0;
        check_vec("stray.req",       64'(bus_if.BusReqOut), 64'd0);
        check_vec("stray.if_ready",  64'(if_ready),         64'd0);
        check_vec("stray.mem_ready", 64'(mem_ready),        64'd0);
        check_vec("stray.if_data",   if_data,               64'h4242);
        check_vec("stray.mem_rdata", mem_rdata,             64'd0);
        step();
        check_vec("stray.after", 64'(if_ready | mem_ready), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
